// File: rtl/instruction_expander_if.sv
// Fetch/memory-side bundle for instruction_expander: the fetch request, the
// completion status, and the micro-op command/handshake toward memory.
interface instruction_expander_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [WIDTH-1:0] instruction_in;
    logic             ready;
    logic             busy;
    logic             illegal;
    logic [WIDTH-1:0] instruction_out;
    logic             start_for_memory;
    logic             ready_for_memory;

    modport master (
        output start, instruction_in, ready_for_memory,
        input  ready, busy, illegal, instruction_out, start_for_memory
    );

    modport slave (
        input  start, instruction_in, ready_for_memory,
        output ready, busy, illegal, instruction_out, start_for_memory
    );
endinterface

// File: rtl/instruction_expander.sv
// Macro-instruction expander: decodes the top byte and streams 0..MAX_UOPS uops to memory.
// INSTRUCTION_EXPANDER_ILLEGAL_TRAP_EN: unknown opcodes trap (illegal) instead of passing through.
module instruction_expander #(
    parameter int               BYTE     = 8,
    parameter int               WIDTH    = 32,
    parameter int               MAX_UOPS = 8,
    parameter logic [BYTE-1:0]  OP_I2B   = 8'h91,
    parameter logic [BYTE-1:0]  OP_BLK   = 8'hA0,
    parameter logic [BYTE-1:0]  OP_MOV   = 8'h92,
    parameter logic [WIDTH-1:0] I2B_UOP  = 32'h920104E0
) (
    input  logic clk,
    input  logic reset,
    instruction_expander_if.slave bus
);
    localparam int CW = $clog2(MAX_UOPS + 1);

    typedef enum logic [1:0] {IDLE, DECODE, SEND, DONE} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] instr_q, instr_n;
    logic [WIDTH-1:0] out_q, out_n;
    logic [CW-1:0]    index, index_n;
    logic [CW-1:0]    count, count_n;
    logic             sfm_q, sfm_n;
    logic             ready_q, ready_n;
    logic             busy_q, busy_n;
    logic             ill_q, ill_n;
    logic             illegal_q, illegal_n;

    logic [BYTE-1:0]  opcode;
    logic [CW-1:0]    dec_count;
    logic [WIDTH-1:0] dec_uop0;
    logic             dec_ill;

    assign opcode = instr_q[WIDTH-1 -: BYTE];

    // Address byte wraps on its own; the upper fields never see a carry.
    function automatic logic [WIDTH-1:0] blk_uop(input logic [CW-1:0] k);
        return {OP_MOV, instr_q[WIDTH-BYTE-1:2*BYTE],
                instr_q[2*BYTE-1:BYTE] + BYTE'(k), {BYTE{1'b0}}};
    endfunction

    always_comb begin
        dec_count = '0;
        dec_uop0  = '0;
        dec_ill   = 1'b0;
        if (opcode == OP_I2B) begin
            dec_count = CW'(1);
            dec_uop0  = I2B_UOP;
        end else if (opcode == OP_BLK) begin
            if (int'(instr_q[BYTE-1:0]) > MAX_UOPS)
                dec_count = CW'(MAX_UOPS);
            else
                dec_count = CW'(instr_q[BYTE-1:0]);
            dec_uop0 = blk_uop('0);
        end else begin
`ifdef INSTRUCTION_EXPANDER_ILLEGAL_TRAP_EN
            dec_ill = 1'b1;
`else
            dec_count = CW'(1);
            dec_uop0  = instr_q;
`endif
        end
    end

    always_comb begin
        state_n   = state;
        instr_n   = instr_q;
        out_n     = out_q;
        index_n   = index;
        count_n   = count;
        sfm_n     = sfm_q;
        busy_n    = busy_q;
        ill_n     = ill_q;
        ready_n   = 1'b0;
        illegal_n = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    instr_n = bus.instruction_in;
                    index_n = '0;
                    busy_n  = 1'b1;
                    state_n = DECODE;
                end
            end
            DECODE: begin
                count_n = dec_count;
                ill_n   = dec_ill;
                if (dec_count != '0) begin
                    out_n   = dec_uop0;
                    sfm_n   = 1'b1;
                    state_n = SEND;
                end else begin
                    state_n = DONE;
                end
            end
            SEND: begin
                if (sfm_q && bus.ready_for_memory) begin
                    if (index == count - CW'(1)) begin
                        sfm_n   = 1'b0;
                        state_n = DONE;
                    end else begin
                        // Next uop is loaded on the same edge: no bubble between handshakes.
                        index_n = index + CW'(1);
                        out_n   = blk_uop(index + CW'(1));
                    end
                end
            end
            DONE: begin
                ready_n   = 1'b1;
                illegal_n = ill_q;
                busy_n    = 1'b0;
                state_n   = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            instr_q   <= '0;
            out_q     <= '0;
            index     <= '0;
            count     <= '0;
            sfm_q     <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            ill_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state     <= state_n;
            instr_q   <= instr_n;
            out_q     <= out_n;
            index     <= index_n;
            count     <= count_n;
            sfm_q     <= sfm_n;
            ready_q   <= ready_n;
            busy_q    <= busy_n;
            ill_q     <= ill_n;
            illegal_q <= illegal_n;
        end
    end

    assign bus.ready            = ready_q;
    assign bus.busy             = busy_q;
    assign bus.illegal          = illegal_q;
    assign bus.instruction_out  = out_q;
    assign bus.start_for_memory = sfm_q;
endmodule

// File: tb/tb_instruction_expander.sv
// Directed bench for instruction_expander: reset, I2B, block expansion with
// address wrap, count clamp, memory stalls, busy-start rejection, unknown opcodes.
module tb_instruction_expander;
    logic clk = 1'b0;
    logic reset;
    int   total  = 0;
    int   passed = 0;

    instruction_expander_if #(.WIDTH(32)) bus ();

    instruction_expander dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic issue(input logic [31:0] instr);
        bus.start          = 1'b1;
        bus.instruction_in = instr;
        tick();
        bus.start          = 1'b0;
        bus.instruction_in = 32'hDEADBEEF;
    endtask

    initial begin
        int          n_uops;
        int          seen_ready;
        logic [31:0] last_uop;

        reset                = 1'b1;
        bus.start            = 1'b0;
        bus.instruction_in   = '0;
        bus.ready_for_memory = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_ready",   {31'd0, bus.ready}, 32'd0);
        check("rst_busy",    {31'd0, bus.busy}, 32'd0);
        check("rst_illegal", {31'd0, bus.illegal}, 32'd0);
        check("rst_sfm",     {31'd0, bus.start_for_memory}, 32'd0);
        check("rst_out",     bus.instruction_out, 32'd0);

        // Reset in the middle of SEND while memory stalls
        issue(32'hA0120005);
        check("mid_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check("mid_sfm", {31'd0, bus.start_for_memory}, 32'd1);
        check("mid_out", bus.instruction_out, 32'h92120000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_sfm",  {31'd0, bus.start_for_memory}, 32'd0);
        check("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        check("mid_rst_out",  bus.instruction_out, 32'd0);

        // I2B: single fixed uop
        bus.ready_for_memory = 1'b1;
        issue(32'h91000000);
        check("i2b_busy", {31'd0, bus.busy}, 32'd1);
        check("i2b_sfm0", {31'd0, bus.start_for_memory}, 32'd0);
        tick();
        check("i2b_sfm1", {31'd0, bus.start_for_memory}, 32'd1);
        check("i2b_uop",  bus.instruction_out, 32'h920104E0);
        tick();
        check("i2b_sfm_off", {31'd0, bus.start_for_memory}, 32'd0);
        check("i2b_not_rdy", {31'd0, bus.ready}, 32'd0);
        tick();
        check("i2b_ready",   {31'd0, bus.ready}, 32'd1);
        check("i2b_illegal", {31'd0, bus.illegal}, 32'd0);
        check("i2b_idle",    {31'd0, bus.busy}, 32'd0);
        tick();
        check("i2b_ready_pulse", {31'd0, bus.ready}, 32'd0);

        // Block of 3 with address wrap FE -> FF -> 00
        issue(32'hA012FE03);
        tick();
        check("blk_u0", bus.instruction_out, 32'h9212FE00);
        tick();
        check("blk_u1", bus.instruction_out, 32'h9212FF00);
        check("blk_u1_sfm", {31'd0, bus.start_for_memory}, 32'd1);
        tick();
        check("blk_u2", bus.instruction_out, 32'h92120000);
        check("blk_u2_sfm", {31'd0, bus.start_for_memory}, 32'd1);
        tick();
        check("blk_sfm_off", {31'd0, bus.start_for_memory}, 32'd0);
        tick();
        check("blk_ready", {31'd0, bus.ready}, 32'd1);
        tick();

        // Block with zero count: no memory traffic
        issue(32'hA0123400);
        tick();
        check("z_sfm", {31'd0, bus.start_for_memory}, 32'd0);
        check("z_busy", {31'd0, bus.busy}, 32'd1);
        tick();
        check("z_ready", {31'd0, bus.ready}, 32'd1);
        check("z_sfm2", {31'd0, bus.start_for_memory}, 32'd0);
        tick();

        // Count field 0x20 clamps to 8 uops; bounded wait for ready
        issue(32'hA0123420);
        n_uops     = 0;
        seen_ready = 0;
        last_uop   = '0;
        for (int c = 0; c < 40 && seen_ready == 0; c++) begin
            if (bus.start_for_memory) begin
                n_uops++;
                last_uop = bus.instruction_out;
            end
            if (bus.ready) seen_ready = 1;
            tick();
        end
        check("clamp_ready_seen", seen_ready, 1);
        check("clamp_count", n_uops, 8);
        check("clamp_last", last_uop, 32'h92123B00);

        // Memory stall on uop1 with start pulses while busy
        issue(32'hA0AB1002);
        tick();
        check("st_u0", bus.instruction_out, 32'h92AB1000);
        tick();
        check("st_u1", bus.instruction_out, 32'h92AB1100);
        bus.ready_for_memory = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.start          = c[0];
            bus.instruction_in = 32'h91000000;
            tick();
            check("st_hold_out", bus.instruction_out, 32'h92AB1100);
            check("st_hold_sfm", {31'd0, bus.start_for_memory}, 32'd1);
        end
        bus.start            = 1'b0;
        bus.ready_for_memory = 1'b1;
        tick();
        check("st_sfm_off", {31'd0, bus.start_for_memory}, 32'd0);
        tick();
        check("st_ready", {31'd0, bus.ready}, 32'd1);
        tick();
        check("st_no_queue_busy", {31'd0, bus.busy}, 32'd0);
        tick();
        check("st_no_queue_sfm", {31'd0, bus.start_for_memory}, 32'd0);
        check("st_no_queue_busy2", {31'd0, bus.busy}, 32'd0);

        // Unrecognised opcode 0x55
        issue(32'h55AABBCC);
        tick();
`ifdef INSTRUCTION_EXPANDER_ILLEGAL_TRAP_EN
        check("ill_sfm", {31'd0, bus.start_for_memory}, 32'd0);
        tick();
        check("ill_ready",   {31'd0, bus.ready}, 32'd1);
        check("ill_illegal", {31'd0, bus.illegal}, 32'd1);
        tick();
        check("ill_clear", {31'd0, bus.illegal}, 32'd0);
`else
        check("pass_sfm", {31'd0, bus.start_for_memory}, 32'd1);
        check("pass_uop", bus.instruction_out, 32'h55AABBCC);
        tick();
        check("pass_sfm_off", {31'd0, bus.start_for_memory}, 32'd0);
        tick();
        check("pass_ready",   {31'd0, bus.ready}, 32'd1);
        check("pass_illegal", {31'd0, bus.illegal}, 32'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
